// File: rtl/sync_fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write-port arbiter: state encodings
// and the width helper used to size the requester index.
package fifo_pkg;

   localparam logic ARB_IDLE  = 1'b0;
   localparam logic ARB_BURST = 1'b1;

   typedef enum logic {
      S_IDLE  = ARB_IDLE,
      S_BURST = ARB_BURST
   } arb_state_e;

   // Returns at least 1 so a 1-bit index still exists for tiny configs.
   function automatic int clog2(input int value);
      int res;
      res = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         res++;
      end
      return (res < 1) ? 1 : res;
   endfunction

endpackage

// File: rtl/sync_fifo_wr_arbiter_if.sv
// Bundle of producer-side and FIFO-side signals around the write arbiter.
// The arbiter uses the slave modport; the producers/FIFO model use master.
interface sync_fifo_wr_arbiter_if #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_REQ    = 4,
   parameter int REQ_IDX_W  = 2
);
   logic [NUM_REQ-1:0]            req;
   logic [NUM_REQ-1:0]            req_last;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            gnt;
   logic                          fifo_full;
   logic                          fifo_wr_en;
   logic [DATA_WIDTH-1:0]         fifo_wr_data;
   logic [REQ_IDX_W-1:0]          owner;
   logic                          busy;

   modport slave (
      input  req,
      input  req_last,
      input  req_data,
      input  fifo_full,
      output gnt,
      output fifo_wr_en,
      output fifo_wr_data,
      output owner,
      output busy
   );

   modport master (
      output req,
      output req_last,
      output req_data,
      output fifo_full,
      input  gnt,
      input  fifo_wr_en,
      input  fifo_wr_data,
      input  owner,
      input  busy
   );
endinterface

// File: rtl/sync_fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request bit strictly after
// last_ptr, wrapping modulo NUM_REQ.
module rr_picker #(
   parameter int NUM_REQ   = 4,
   parameter int REQ_IDX_W = 2
) (
   input  logic [NUM_REQ-1:0]   req,
   input  logic [REQ_IDX_W-1:0] last_ptr,
   output logic                 valid,
   output logic [REQ_IDX_W-1:0] idx
);

   // Scan from the farthest candidate to the nearest so the nearest set bit
   // is the last one written and therefore wins.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         if (req[(int'(last_ptr) + k) % NUM_REQ]) begin
            valid = 1'b1;
            idx   = REQ_IDX_W'((int'(last_ptr) + k) % NUM_REQ);
         end
      end
   end

endmodule

// File: rtl/sync_fifo_wr_arbiter.sv
// Round-robin arbiter sharing one sync_fifo write port among NUM_REQ
// producers, granting bounded bursts and stalling on fifo_full.
module sync_fifo_wr_arbiter
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_REQ    = 4,
   parameter int REQ_IDX_W  = clog2(NUM_REQ),
   parameter int MAX_BURST  = 4,
   parameter int BURST_W    = 3
) (
   input  logic                   clk,
   input  logic                   rst_n,
   sync_fifo_wr_arbiter_if.slave  bus
);

   localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);

   arb_state_e           state, state_nx;
   logic [REQ_IDX_W-1:0] owner, owner_nx;
   logic [REQ_IDX_W-1:0] last_ptr, last_ptr_nx;
   logic [BURST_W-1:0]   burst_cnt, burst_cnt_nx;

   logic                  pick_valid;
   logic [REQ_IDX_W-1:0]  pick_idx;
   logic                  wr_en_c;
   logic [DATA_WIDTH-1:0] wr_data_c;
   logic [NUM_REQ-1:0]    gnt_c;

   rr_picker #(
      .NUM_REQ   (NUM_REQ),
      .REQ_IDX_W (REQ_IDX_W)
   ) u_picker (
      .req      (bus.req),
      .last_ptr (last_ptr),
      .valid    (pick_valid),
      .idx      (pick_idx)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         owner     <= '0;
         last_ptr  <= REQ_IDX_W'(NUM_REQ - 1);
         burst_cnt <= '0;
      end else begin
         state     <= state_nx;
         owner     <= owner_nx;
         last_ptr  <= last_ptr_nx;
         burst_cnt <= burst_cnt_nx;
      end
   end

   always_comb begin
      state_nx     = state;
      owner_nx     = owner;
      last_ptr_nx  = last_ptr;
      burst_cnt_nx = burst_cnt;
      wr_en_c      = 1'b0;
      wr_data_c    = '0;
      gnt_c        = '0;
      unique case (state)
         S_IDLE: begin
            if (pick_valid && !bus.fifo_full) begin
               owner_nx     = pick_idx;
               burst_cnt_nx = '0;
               state_nx     = S_BURST;
            end
         end
         S_BURST: begin
            // A withdrawn request closes the burst even while the FIFO is full.
            if (!bus.req[owner]) begin
               last_ptr_nx = owner;
               state_nx    = S_IDLE;
            end else if (!bus.fifo_full) begin
               wr_en_c      = 1'b1;
               wr_data_c    = bus.req_data[int'(owner)*DATA_WIDTH +: DATA_WIDTH];
               gnt_c[owner] = 1'b1;
               burst_cnt_nx = burst_cnt + 1'b1;
               if (bus.req_last[owner] || (burst_cnt == BURST_LAST)) begin
                  last_ptr_nx = owner;
                  state_nx    = S_IDLE;
               end
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   assign bus.fifo_wr_en   = wr_en_c;
   assign bus.fifo_wr_data = wr_data_c;
   assign bus.gnt          = gnt_c;
   assign bus.owner        = owner;
   assign bus.busy         = (state == S_BURST);

endmodule

// File: tb/tb_sync_fifo_wr_arbiter.sv
// Directed, table-driven bench for sync_fifo_wr_arbiter with hand-written
// sequences for reset-state and asynchronous mid-burst reset.
module tb_sync_fifo_wr_arbiter;

   logic clk;
   logic rst_n;

   sync_fifo_wr_arbiter_if #(.DATA_WIDTH(8), .NUM_REQ(4), .REQ_IDX_W(2)) bus ();

   sync_fifo_wr_arbiter #(
      .DATA_WIDTH (8),
      .NUM_REQ    (4),
      .REQ_IDX_W  (2),
      .MAX_BURST  (4),
      .BURST_W    (3)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  req;
      logic [3:0]  last;
      logic [31:0] data;
      logic        full;
      logic [3:0]  e_gnt;
      logic        e_wr;
      logic [7:0]  e_data;
      logic [1:0]  e_owner;
      logic        e_busy;
   } vec_t;

   vec_t vecs[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic add(input logic [3:0] req, input logic [3:0] last,
                      input logic [31:0] data, input logic full,
                      input logic [3:0] e_gnt, input logic e_wr,
                      input logic [7:0] e_data, input logic [1:0] e_owner,
                      input logic e_busy);
      vec_t v;
      v.req = req; v.last = last; v.data = data; v.full = full;
      v.e_gnt = e_gnt; v.e_wr = e_wr; v.e_data = e_data;
      v.e_owner = e_owner; v.e_busy = e_busy;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [3:0] gnt,
                            input logic wr, input logic [7:0] data,
                            input logic [1:0] owner, input logic busy);
      check({tag, " gnt"},   32'(bus.gnt),          32'(gnt));
      check({tag, " wr_en"}, 32'(bus.fifo_wr_en),   32'(wr));
      check({tag, " data"},  32'(bus.fifo_wr_data), 32'(data));
      check({tag, " owner"}, 32'(bus.owner),        32'(owner));
      check({tag, " busy"},  32'(bus.busy),         32'(busy));
   endtask

   task automatic drive(input logic [3:0] req, input logic [3:0] last,
                        input logic [31:0] data, input logic full);
      bus.req       = req;
      bus.req_last  = last;
      bus.req_data  = data;
      bus.fifo_full = full;
   endtask

   initial begin
      // Round robin from reset: 1-word packets, grant order 0,1,2,3,0.
      for (int i = 0; i < 5; i++) begin
         add(4'hF, 4'hF, 32'h13121110, 1'b0, 4'h0, 1'b0, 8'h00,
             (i == 0) ? 2'd0 : 2'(i - 1), 1'b0);
         add(4'hF, 4'hF, 32'h13121110, 1'b0, 4'(1 << (i % 4)), 1'b1,
             8'(8'h10 + (i % 4)), 2'(i % 4), 1'b1);
      end
      // Single requester, 4-word packet.
      add(4'h1, 4'h0, 32'h000000A1, 1'b0, 4'h0, 1'b0, 8'h00, 2'd0, 1'b0);
      add(4'h1, 4'h0, 32'h000000A1, 1'b0, 4'h1, 1'b1, 8'hA1, 2'd0, 1'b1);
      add(4'h1, 4'h0, 32'h000000A2, 1'b0, 4'h1, 1'b1, 8'hA2, 2'd0, 1'b1);
      add(4'h1, 4'h0, 32'h000000A3, 1'b0, 4'h1, 1'b1, 8'hA3, 2'd0, 1'b1);
      add(4'h1, 4'h1, 32'h000000A4, 1'b0, 4'h1, 1'b1, 8'hA4, 2'd0, 1'b1);
      // Withdraw: owner 1 drops after word 1, then 3 beats 1.
      add(4'hA, 4'h0, 32'hD100C100, 1'b0, 4'h0, 1'b0, 8'h00, 2'd0, 1'b0);
      add(4'hA, 4'h0, 32'hD100C100, 1'b0, 4'h2, 1'b1, 8'hC1, 2'd1, 1'b1);
      add(4'h8, 4'h0, 32'hD1000000, 1'b0, 4'h0, 1'b0, 8'h00, 2'd1, 1'b1);
      add(4'hA, 4'h0, 32'hD100C200, 1'b0, 4'h0, 1'b0, 8'h00, 2'd1, 1'b0);
      add(4'hA, 4'h8, 32'hD100C200, 1'b0, 4'h8, 1'b1, 8'hD1, 2'd3, 1'b1);
      add(4'h2, 4'h2, 32'h0000C200, 1'b0, 4'h0, 1'b0, 8'h00, 2'd3, 1'b0);
      add(4'h2, 4'h2, 32'h0000C200, 1'b0, 4'h2, 1'b1, 8'hC2, 2'd1, 1'b1);
      // Burst cap: requester 2 streams 6 words, split 4 + 2.
      add(4'h4, 4'h0, 32'h00B10000, 1'b0, 4'h0, 1'b0, 8'h00, 2'd1, 1'b0);
      for (int i = 0; i < 4; i++)
         add(4'h4, 4'h0, {8'h00, 8'(8'hB1 + i), 16'h0000}, 1'b0,
             4'h4, 1'b1, 8'(8'hB1 + i), 2'd2, 1'b1);
      add(4'h4, 4'h0, 32'h00B50000, 1'b0, 4'h0, 1'b0, 8'h00, 2'd2, 1'b0);
      add(4'h4, 4'h0, 32'h00B50000, 1'b0, 4'h4, 1'b1, 8'hB5, 2'd2, 1'b1);
      add(4'h4, 4'h4, 32'h00B60000, 1'b0, 4'h4, 1'b1, 8'hB6, 2'd2, 1'b1);
      add(4'h0, 4'h0, 32'h00000000, 1'b0, 4'h0, 1'b0, 8'h00, 2'd2, 1'b0);
      // Full stall for 3 cycles after word 2; full in IDLE blocks arbitration.
      add(4'h1, 4'h0, 32'h000000E1, 1'b0, 4'h0, 1'b0, 8'h00, 2'd2, 1'b0);
      add(4'h1, 4'h0, 32'h000000E1, 1'b0, 4'h1, 1'b1, 8'hE1, 2'd0, 1'b1);
      add(4'h1, 4'h0, 32'h000000E2, 1'b0, 4'h1, 1'b1, 8'hE2, 2'd0, 1'b1);
      for (int i = 0; i < 3; i++)
         add(4'h1, 4'h0, 32'h000000E3, 1'b1, 4'h0, 1'b0, 8'h00, 2'd0, 1'b1);
      add(4'h1, 4'h0, 32'h000000E3, 1'b0, 4'h1, 1'b1, 8'hE3, 2'd0, 1'b1);
      add(4'h1, 4'h1, 32'h000000E4, 1'b0, 4'h1, 1'b1, 8'hE4, 2'd0, 1'b1);
      add(4'h1, 4'h0, 32'h000000E5, 1'b1, 4'h0, 1'b0, 8'h00, 2'd0, 1'b0);
      add(4'h1, 4'h0, 32'h000000E5, 1'b1, 4'h0, 1'b0, 8'h00, 2'd0, 1'b0);
      add(4'h0, 4'h0, 32'h00000000, 1'b0, 4'h0, 1'b0, 8'h00, 2'd0, 1'b0);

      rst_n = 1'b0;
      drive(4'h0, 4'h0, 32'h0, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      check_all("reset", 4'h0, 1'b0, 8'h00, 2'd0, 1'b0);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         drive(vecs[i].req, vecs[i].last, vecs[i].data, vecs[i].full);
         #1;
         check_all($sformatf("vec%0d", i), vecs[i].e_gnt, vecs[i].e_wr,
                   vecs[i].e_data, vecs[i].e_owner, vecs[i].e_busy);
      end

      // Asynchronous reset during word 2 of requester 1's burst.
      @(negedge clk);
      drive(4'h2, 4'h0, 32'h0000F100, 1'b0);
      #1;
      check_all("rst_arb", 4'h0, 1'b0, 8'h00, 2'd0, 1'b0);
      @(negedge clk);
      #1;
      check_all("rst_w1", 4'h2, 1'b1, 8'hF1, 2'd1, 1'b1);
      @(negedge clk);
      bus.req_data = 32'h0000F200;
      #1;
      check_all("rst_w2", 4'h2, 1'b1, 8'hF2, 2'd1, 1'b1);
      #1;
      rst_n = 1'b0;
      #1;
      check_all("rst_async", 4'h0, 1'b0, 8'h00, 2'd0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(4'h3, 4'h0, 32'h0000F255, 1'b0);
      #1;
      check_all("rst_rel", 4'h0, 1'b0, 8'h00, 2'd0, 1'b0);
      @(negedge clk);
      #1;
      check_all("rst_first", 4'h1, 1'b1, 8'h55, 2'd0, 1'b1);
      @(negedge clk);
      drive(4'h0, 4'h0, 32'h0, 1'b0);
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
